// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit-queue FSM states and default sizes
// used by both the transmit queue and the receive FIFO.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } tx_q_state_t;

  localparam int DATA_BITS_DEF  = 8;
  localparam int FIFO_WIDTH_DEF = 3;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single-bit level crossing into SysClk.
module sync_2ff (
  input  logic SysClk,
  input  logic Rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  // Two back-to-back flops; the first may go metastable, the second settles it.
  always_ff @(posedge SysClk) begin
    if (Rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/tx_queue_ctrl.sv
// Transmit queue: circular FIFO of host bytes plus a launch FSM that hands
// one byte at a time to the transmitter over a Transmit_Start/Tx_Busy level
// handshake, abandoning a launch the transmitter never acknowledges.
module tx_queue_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS     = DATA_BITS_DEF,
  parameter int FIFO_WIDTH    = FIFO_WIDTH_DEF,
  parameter int START_TIMEOUT = 4096
) (
  input  logic                 SysClk,
  input  logic                 Rst,
  input  logic                 Push_Data,
  input  logic [DATA_BITS-1:0] Tx_Data_In,
  input  logic                 Tx_Busy,
  input  logic                 BIST_Mode,
  output logic [DATA_BITS-1:0] Tx_Data_Out,
  output logic                 Transmit_Start,
  output logic                 FIFO_Empty,
  output logic                 FIFO_Full,
  output logic                 FIFO_Overflow,
  output logic                 Tx_Timeout
);

  localparam int DEPTH = 1 << FIFO_WIDTH;
  localparam int TW    = $clog2(START_TIMEOUT) + 1;
  localparam logic [FIFO_WIDTH:0] DEPTH_C  = (FIFO_WIDTH+1)'(DEPTH);
  localparam logic [TW-1:0]       TMO_LAST = TW'(START_TIMEOUT - 1);

  logic [DATA_BITS-1:0]  mem_q [DEPTH];
  logic [FIFO_WIDTH-1:0] wptr_q, rptr_q;
  logic [FIFO_WIDTH:0]   count_q, count_d;
  logic                  empty_q, full_q, ovf_q;

  tx_q_state_t           state_q;
  logic [TW-1:0]         tmo_cnt_q;
  logic [DATA_BITS-1:0]  data_q;
  logic                  start_q, tmo_q;

  logic busy_s;
  logic push_ok, push_drop, pop;

  sync_2ff u_busy_sync (
    .SysClk (SysClk),
    .Rst    (Rst),
    .d_i    (Tx_Busy),
    .q_o    (busy_s)
  );

  // Full test uses the registered count, so a push into a full queue is
  // dropped even when a pop frees a slot on the same edge.
  assign push_ok   = Push_Data && (count_q != DEPTH_C);
  assign push_drop = Push_Data && (count_q == DEPTH_C);
  assign pop       = (state_q == IDLE) && !empty_q && !BIST_Mode;

  // Occupancy next-state from the push/pop pair.
  always_comb begin
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage array; contents need no reset since the pointers define validity.
  always_ff @(posedge SysClk) begin
    if (push_ok) mem_q[wptr_q] <= Tx_Data_In;
  end

  // Pointers, occupancy and the registered empty/full/overflow flags.
  always_ff @(posedge SysClk) begin
    if (Rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (push_ok)   wptr_q <= wptr_q + 1'b1;
      if (pop)       rptr_q <= rptr_q + 1'b1;
      if (push_drop) ovf_q  <= 1'b1;
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == DEPTH_C);
    end
  end

  // Launch FSM with registered Transmit_Start, data and timeout flag.
  always_ff @(posedge SysClk) begin
    if (Rst) begin
      state_q   <= IDLE;
      tmo_cnt_q <= '0;
      data_q    <= '0;
      start_q   <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            data_q    <= mem_q[rptr_q];
            tmo_cnt_q <= '0;
            start_q   <= 1'b1;
            state_q   <= START;
          end
        end
        START: begin
          if (busy_s) begin
            start_q <= 1'b0;
            state_q <= WAIT_DONE;
          end else if (tmo_cnt_q == TMO_LAST) begin
            // Transmitter never answered: drop this byte and move on.
            tmo_q   <= 1'b1;
            start_q <= 1'b0;
            state_q <= IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!busy_s) state_q <= IDLE;
        end
        default: begin
          start_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Tx_Data_Out    = data_q;
  assign Transmit_Start = start_q;
  assign FIFO_Empty     = empty_q;
  assign FIFO_Full      = full_q;
  assign FIFO_Overflow  = ovf_q;
  assign Tx_Timeout     = tmo_q;

endmodule

// File: tb/tb_tx_queue_ctrl.sv
// Scoreboard bench for tx_queue_ctrl: expected bytes are queued as they are
// pushed and compared whenever Transmit_Start rises.
module tb_tx_queue_ctrl;

  logic       SysClk = 1'b0;
  logic       Rst = 1'b1;
  logic       Push_Data = 1'b0;
  logic [7:0] Tx_Data_In = '0;
  logic       Tx_Busy = 1'b0;
  logic       BIST_Mode = 1'b0;
  logic [7:0] Tx_Data_Out;
  logic       Transmit_Start, FIFO_Empty, FIFO_Full, FIFO_Overflow, Tx_Timeout;

  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   launches = 0;
  logic resp_en = 1'b0;
  logic start_prev = 1'b0;
  logic [7:0] exp_q [$];

  tx_queue_ctrl #(.DATA_BITS(8), .FIFO_WIDTH(3), .START_TIMEOUT(4096)) dut (
    .SysClk         (SysClk),
    .Rst            (Rst),
    .Push_Data      (Push_Data),
    .Tx_Data_In     (Tx_Data_In),
    .Tx_Busy        (Tx_Busy),
    .BIST_Mode      (BIST_Mode),
    .Tx_Data_Out    (Tx_Data_Out),
    .Transmit_Start (Transmit_Start),
    .FIFO_Empty     (FIFO_Empty),
    .FIFO_Full      (FIFO_Full),
    .FIFO_Overflow  (FIFO_Overflow),
    .Tx_Timeout     (Tx_Timeout)
  );

  always #5 SysClk = ~SysClk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every rising Transmit_Start must carry the oldest pending byte.
  always @(negedge SysClk) begin
    if (!Rst && Transmit_Start && !start_prev) begin
      launches++;
      if (exp_q.size() == 0) chk("unexpected_launch", {24'h0, Tx_Data_Out}, 32'hFFFF_FFFF);
      else                   chk("launch_byte", {24'h0, Tx_Data_Out}, {24'h0, exp_q.pop_front()});
    end
    start_prev = Transmit_Start;
  end

  // Transmitter model: busy 3 cycles after a start, held for 20 cycles.
  initial begin
    forever begin
      @(negedge SysClk);
      if (resp_en && Transmit_Start && !Tx_Busy) begin
        repeat (2) @(negedge SysClk);
        Tx_Busy = 1'b1;
        repeat (20) @(negedge SysClk);
        Tx_Busy = 1'b0;
      end
    end
  end

  task automatic push(input logic [7:0] b, input bit expect_out);
    Push_Data  = 1'b1;
    Tx_Data_In = b;
    if (expect_out) exp_q.push_back(b);
    @(negedge SysClk);
    Push_Data  = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (!(exp_q.size() == 0 && FIFO_Empty && !Transmit_Start && !Tx_Busy) && n < 3000) begin
      @(negedge SysClk);
      n++;
    end
    if (n >= 3000) chk({tag, "_drain_timeout"}, 0, 1);
    repeat (5) @(negedge SysClk);
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    repeat (2) @(negedge SysClk);
    Rst = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    int n;
    do_reset();

    // Reset state
    chk("rst_empty", FIFO_Empty, 1);
    chk("rst_full", FIFO_Full, 0);
    chk("rst_ovf", FIFO_Overflow, 0);
    chk("rst_tmo", Tx_Timeout, 0);
    chk("rst_start", Transmit_Start, 0);
    chk("rst_data", Tx_Data_Out, 0);

    // Single byte with hand-driven Tx_Busy to check handshake timing
    push(8'hA5, 1);
    chk("t1_not_empty", FIFO_Empty, 0);
    chk("t1_start_lat", Transmit_Start, 0);
    @(negedge SysClk);
    chk("t1_start_hi", Transmit_Start, 1);
    chk("t1_data", Tx_Data_Out, 8'hA5);
    chk("t1_empty_again", FIFO_Empty, 1);
    repeat (2) @(negedge SysClk);
    Tx_Busy = 1'b1;
    @(negedge SysClk); chk("t1_start_b1", Transmit_Start, 1);
    @(negedge SysClk); chk("t1_start_b2", Transmit_Start, 1);
    @(negedge SysClk); chk("t1_start_b3", Transmit_Start, 0);
    chk("t1_data_hold", Tx_Data_Out, 8'hA5);
    repeat (17) @(negedge SysClk);
    Tx_Busy = 1'b0;
    repeat (5) @(negedge SysClk);
    chk("t1_data_idle", Tx_Data_Out, 8'hA5);
    resp_en = 1'b1;

    // Fill and overflow with launches held off
    BIST_Mode = 1'b1;
    for (int i = 0; i < 9; i++) begin
      push(i[7:0], i < 8);
      if (i == 6) chk("t2_not_full7", FIFO_Full, 0);
      if (i == 7) begin
        chk("t2_full", FIFO_Full, 1);
        chk("t2_no_ovf_yet", FIFO_Overflow, 0);
      end
    end
    chk("t2_ovf", FIFO_Overflow, 1);
    chk("t2_no_launch", Transmit_Start, 0);
    BIST_Mode = 1'b0;
    wait_drain("t2");
    chk("t2_ovf_sticky", FIFO_Overflow, 1);
    chk("t2_empty", FIFO_Empty, 1);

    // Wrap-around across the pointer boundary
    BIST_Mode = 1'b1;
    for (int i = 0; i < 6; i++) push(8'h40 + i[7:0], 1);
    BIST_Mode = 1'b0;
    wait_drain("t3a");
    for (int i = 0; i < 5; i++) push(8'h80 + i[7:0], 1);
    wait_drain("t3b");

    // Launch timeout with no transmitter response
    resp_en = 1'b0;
    push(8'h3C, 1);
    @(negedge SysClk);
    chk("t4_start", Transmit_Start, 1);
    n = 0;
    while (Transmit_Start && n < 5000) begin
      @(negedge SysClk);
      n++;
    end
    chk("t4_start_len", n, 4096);
    chk("t4_tmo", Tx_Timeout, 1);
    resp_en = 1'b1;
    push(8'h5A, 1);
    wait_drain("t4");
    chk("t4_tmo_sticky", Tx_Timeout, 1);

    // Push into a full queue on the same edge as a pop
    do_reset();
    BIST_Mode = 1'b1;
    for (int i = 0; i < 8; i++) push(8'h10 + i[7:0], 1);
    chk("t5_full", FIFO_Full, 1);
    BIST_Mode = 1'b0;
    push(8'hEE, 0);
    chk("t5_not_full", FIFO_Full, 0);
    chk("t5_ovf", FIFO_Overflow, 1);
    chk("t5_not_empty", FIFO_Empty, 0);
    chk("t5_start", Transmit_Start, 1);
    wait_drain("t5");

    // Reset while the first of three bytes is in WAIT_DONE
    BIST_Mode = 1'b1;
    push(8'hC1, 1);
    push(8'hC2, 0);
    push(8'hC3, 0);
    BIST_Mode = 1'b0;
    n = 0;
    while (!(Tx_Busy && !Transmit_Start && launches > 0) && n < 100) begin
      @(negedge SysClk);
      n++;
    end
    chk("t6_reach_wait", n < 100, 1);
    n = launches;
    Rst = 1'b1;
    @(negedge SysClk);
    Rst = 1'b0;
    chk("t6_start", Transmit_Start, 0);
    chk("t6_empty", FIFO_Empty, 1);
    chk("t6_full", FIFO_Full, 0);
    chk("t6_ovf", FIFO_Overflow, 0);
    chk("t6_tmo", Tx_Timeout, 0);
    chk("t6_data", Tx_Data_Out, 0);
    repeat (100) @(negedge SysClk);
    chk("t6_no_launch", launches, n);
    chk("t6_pending", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/tx_queue_ctrl.md
# tx_queue_ctrl

Transmit-side queue and launch controller for the UART: buffers host bytes in a circular FIFO on the system clock and hands them one at a time to the transmitter FSM through a level handshake on Transmit_Start / Tx_Busy. It is the outbound counterpart of the receive FIFO. It sits between the host port and the transmitter's Tx_Data / Transmit_Start inputs, ahead of the BIST mux.

## Interface
Parameters:
- DATA_BITS, 8: byte width.
- FIFO_WIDTH, 3: address width; depth = 2**FIFO_WIDTH entries.
- START_TIMEOUT, 4096: SysClk cycles allowed for Tx_Busy to rise after Transmit_Start asserts.

Ports:
- SysClk  in  1  system clock; the only clock.
- Rst  in  1  synchronous, active-high reset.
- Push_Data  in  1  write strobe; one byte per high cycle.
- Tx_Data_In  in  DATA_BITS  byte to enqueue.
- Tx_Busy  in  1  transmitter busy, baud-clock domain; internally synchronized.
- BIST_Mode  in  1  high = hold off launching new bytes.
- Tx_Data_Out  out  DATA_BITS  byte presented to the transmitter.
- Transmit_Start  out  1  launch request, level.
- FIFO_Empty  out  1  queue holds 0 entries.
- FIFO_Full  out  1  queue holds 2**FIFO_WIDTH entries.
- FIFO_Overflow  out  1  sticky; a push was dropped.
- Tx_Timeout  out  1  sticky; a launch was abandoned.

## Operation
- Storage: circular buffer with FIFO_WIDTH-bit read and write pointers, plus a count of FIFO_WIDTH+1 bits. Pointers wrap modulo depth.
- Push: Push_Data high and count < depth writes mem[wptr], then wptr+1 and count+1. Push while FIFO_Full drops the byte and sets FIFO_Overflow. This holds even if a pop occurs in the same cycle, because the full check uses the registered count.
- Simultaneous push and pop when not full: count is unchanged and both pointers advance.
- Tx_Busy passes through a 2-flop synchronizer to give busy_s.
- FSM states: IDLE, START, WAIT_DONE.
  - IDLE: if !FIFO_Empty and !BIST_Mode, pop: Tx_Data_Out <= mem[rptr], rptr+1, count-1, clear timeout counter, go to START.
  - START: Transmit_Start = 1. If busy_s = 1, go to WAIT_DONE. If the timeout counter reaches START_TIMEOUT-1, set Tx_Timeout, drop the byte and go to IDLE. Otherwise increment the counter.
  - WAIT_DONE: Transmit_Start = 0. When busy_s = 0, go to IDLE.
- Tx_Data_Out is stable from the pop through the end of WAIT_DONE. It keeps its last value in IDLE.
- BIST_Mode rising while in START or WAIT_DONE does not abort the current byte; it only blocks the next pop. Pushes are accepted regardless of BIST_Mode.
- Overflow and timeout flags clear only on Rst.

## Timing
- Reset values: Tx_Data_Out = 0, Transmit_Start = 0, FIFO_Empty = 1, FIFO_Full = 0, FIFO_Overflow = 0, Tx_Timeout = 0. State = IDLE, pointers = 0, count = 0, synchronizer flops = 0.
- Rst asserted in any state returns everything to reset values at the next edge. Queued bytes are discarded and Transmit_Start drops at that edge.
- FIFO_Empty and FIFO_Full are registered from count and update at the edge after a push or pop.
- Launch latency: Push_Data sampled at edge N into an empty idle queue gives FIFO_Empty = 0 after edge N. The pop happens at edge N+1, and Transmit_Start = 1 and Tx_Data_Out valid from edge N+1.
- busy_s lags Tx_Busy by 2 SysClk edges. Transmit_Start falls at the edge after busy_s is sampled high.
- Back-to-back bytes: the next pop occurs at the edge after busy_s is seen low, i.e. 1 cycle spent in IDLE.

## Structure
- Shared package uart_pkg holds:
  - typedef enum logic [1:0] tx_q_state_t {IDLE, START, WAIT_DONE};
  - default constants for DATA_BITS and FIFO_WIDTH, shared with the receive FIFO.
- One sub-module, sync_2ff (1-bit, SysClk, Rst), for Tx_Busy. It is reusable for the receive path.
- Storage is a plain register array inside tx_queue_ctrl; no memory macro.

## Test plan
- Single byte: push 0xA5 with a responder raising Tx_Busy 3 cycles after Transmit_Start and dropping it 20 cycles later.
  - Transmit_Start high one cycle after the push edge, with Tx_Data_Out = 0xA5.
  - Start falls 3 cycles after busy rises; FIFO_Empty returns to 1.
- Fill and overflow (depth 8): push 0x00..0x08 with BIST_Mode = 1.
  - FIFO_Full = 1 after the 8th push; the 9th byte is dropped and FIFO_Overflow = 1.
  - Release BIST_Mode: bytes 0x00..0x07 come out in order and Overflow stays 1.
- Wrap-around: with BIST_Mode = 1, push 6 bytes; release BIST_Mode and let all 6 drain.
  - Then push 5 more (pointers cross 7 to 0); output order is preserved.
- Timeout: push 0x3C with Tx_Busy held 0.
  - Transmit_Start stays high for 4096 cycles, then Tx_Timeout = 1 and the FSM returns to IDLE.
  - A following byte launches normally.
- Reset mid-transfer: queue 3 bytes, assert Rst during WAIT_DONE.
  - Next edge: Transmit_Start = 0, FIFO_Empty = 1, and all flags 0.
  - No queued byte launches afterwards.
- Push while full with simultaneous pop: the byte is dropped, Overflow is set, and count = 7 after that edge.
